watch_core: RTL and testbench

//  Time-keeping datapath fed by the run/display/clear mode levels from the button

---
 rtl/watch_core.sv | 236 +++++++++++++++++++++++
 tb/tb_watch_core.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/watch_core.sv
// -----------------------------------------------------------------------------
// watch_core
// Time-keeping datapath for the watch. Two time bases run here:
//   * a 1/100 s stopwatch (MM:SS.CC). The run, display and clear levels from the
//     button controller drive it through a small IDLE/RUN/PAUSE state machine.
//   * a 24 h clock (HH:MM:SS) that runs all the time.
// Four registered BCD digits, the decimal-point mask and the colon go to the
// FND driver.
//
// Parameters
//   CLK_HZ   input clock frequency
//   TICK_HZ  base tick rate; one stopwatch centisecond per tick
//
// Ports
//   clk       in   system clock
//   rst       in   synchronous reset, active low
//   run_md    in   level: 1 = stopwatch running, 0 = stopped
//   disp_md   in   level: 0 = stopwatch view, 1 = clock view
//   clr_on    in   level: clear request, honoured only in PAUSE with run_md = 0
//   digits    out  BCD {d3,d2,d1,d0}, d3 leftmost
//   dp_mask   out  decimal point per digit, bit3 = d3
//   colon     out  colon LED, blinks at 1 Hz in clock view
//   sw_state  out  00 IDLE, 01 RUN, 10 PAUSE
// -----------------------------------------------------------------------------
module watch_core #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_md,
    input  logic        disp_md,
    input  logic        clr_on,
    output logic [15:0] digits,
    output logic [3:0]  dp_mask,
    output logic        colon,
    output logic [1:0]  sw_state
);

    localparam int DIV_MAX = CLK_HZ / TICK_HZ - 1;
    localparam int DIV_W   = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
    localparam int SUB_W   = (TICK_HZ > 1) ? $clog2(TICK_HZ) : 1;

    typedef enum logic [1:0] {
        SW_IDLE  = 2'b00,
        SW_RUN   = 2'b01,
        SW_PAUSE = 2'b10
    } sw_state_t;

    // ---------------------------------------------------------------- tick
    // Free-running divider. The run and clear levels never touch it, so the
    // first stopwatch increment after a start lands anywhere within one tick
    // period.
    logic [DIV_W-1:0] div_reg, div_next;
    logic             tick;

    assign tick = (div_reg == DIV_W'(DIV_MAX));

    always_comb begin
        div_next = div_reg + 1'b1;
        if (tick) begin
            div_next = '0;
        end
    end

    // --------------------------------------------------------------- clock
    logic [SUB_W-1:0] clk_sub_reg, clk_sub_next;
    logic [5:0]       clk_sec_reg, clk_sec_next;
    logic [5:0]       clk_min_reg, clk_min_next;
    logic [4:0]       clk_hour_reg, clk_hour_next;

    always_comb begin
        clk_sub_next  = clk_sub_reg;
        clk_sec_next  = clk_sec_reg;
        clk_min_next  = clk_min_reg;
        clk_hour_next = clk_hour_reg;
        if (tick) begin
            if (clk_sub_reg == SUB_W'(TICK_HZ - 1)) begin
                clk_sub_next = '0;
                if (clk_sec_reg == 6'd59) begin
                    clk_sec_next = '0;
                    if (clk_min_reg == 6'd59) begin
                        clk_min_next  = '0;
                        clk_hour_next = (clk_hour_reg == 5'd23) ? 5'd0 : clk_hour_reg + 5'd1;
                    end else begin
                        clk_min_next = clk_min_reg + 6'd1;
                    end
                end else begin
                    clk_sec_next = clk_sec_reg + 6'd1;
                end
            end else begin
                clk_sub_next = clk_sub_reg + 1'b1;
            end
        end
    end

    // ------------------------------------------------------ stopwatch FSM
    sw_state_t state_reg, state_next;
    logic      sw_count;   // advance the stopwatch by one centisecond
    logic      sw_clear;   // force stopwatch counters to zero

    always_comb begin
        state_next = state_reg;
        sw_count   = 1'b0;
        sw_clear   = 1'b0;
        case (state_reg)
            SW_IDLE: begin
                sw_clear = 1'b1;
                if (run_md) begin
                    state_next = SW_RUN;
                end
            end
            SW_RUN: begin
                // A tick in the cycle run_md drops is discarded.
                if (!run_md) begin
                    state_next = SW_PAUSE;
                end else if (tick) begin
                    sw_count = 1'b1;
                end
            end
            SW_PAUSE: begin
                // Run has priority over clear when both are requested.
                if (run_md) begin
                    state_next = SW_RUN;
                end else if (clr_on) begin
                    state_next = SW_IDLE;
                    sw_clear   = 1'b1;
                end
            end
            default: begin
                state_next = SW_IDLE;
                sw_clear   = 1'b1;
            end
        endcase
    end

    // -------------------------------------------------- stopwatch counters
    logic [6:0] sw_csec_reg, sw_csec_next;
    logic [5:0] sw_sec_reg, sw_sec_next;
    logic [5:0] sw_min_reg, sw_min_next;

    always_comb begin
        sw_csec_next = sw_csec_reg;
        sw_sec_next  = sw_sec_reg;
        sw_min_next  = sw_min_reg;
        if (sw_clear) begin
            sw_csec_next = '0;
            sw_sec_next  = '0;
            sw_min_next  = '0;
        end else if (sw_count) begin
            if (sw_csec_reg == 7'd99) begin
                sw_csec_next = '0;
                if (sw_sec_reg == 6'd59) begin
                    sw_sec_next = '0;
                    sw_min_next = (sw_min_reg == 6'd59) ? 6'd0 : sw_min_reg + 6'd1;
                end else begin
                    sw_sec_next = sw_sec_reg + 6'd1;
                end
            end else begin
                sw_csec_next = sw_csec_reg + 7'd1;
            end
        end
    end

    // --------------------------------------------------------- display mux
    // field_bin[13:7] feeds d3:d2 and field_bin[6:0] feeds d1:d0. All
    // fields are below 100, so the tens/ones split always yields digits 0..9.
    logic [13:0] field_bin;
    logic [15:0] digits_next;
    logic [3:0]  dp_next;
    logic        colon_next;

    always_comb begin
        field_bin  = {1'b0, sw_sec_reg, sw_csec_reg};
        dp_next    = 4'b0100;
        colon_next = 1'b0;
        if (disp_md) begin
            field_bin  = {2'b00, clk_hour_reg, 1'b0, clk_min_reg};
            dp_next    = 4'b0000;
            colon_next = (clk_sub_reg < SUB_W'(TICK_HZ / 2));
        end else if (sw_min_reg != 6'd0) begin
            field_bin = {1'b0, sw_min_reg, 1'b0, sw_sec_reg};
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_bcd
        logic [6:0] bin_val;
        logic [3:0] tens_val;
        logic [3:0] ones_val;
        assign bin_val  = field_bin[gi*7 +: 7];
        assign tens_val = 4'(bin_val / 7'd10);
        assign ones_val = 4'(bin_val % 7'd10);
        assign digits_next[gi*8 +: 8] = {tens_val, ones_val};
    end

    // ------------------------------------------------------------ registers
    logic [15:0] digits_reg;
    logic [3:0]  dp_reg;
    logic        colon_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_reg      <= '0;
            clk_sub_reg  <= '0;
            clk_sec_reg  <= '0;
            clk_min_reg  <= '0;
            clk_hour_reg <= '0;
            state_reg    <= SW_IDLE;
            sw_csec_reg  <= '0;
            sw_sec_reg   <= '0;
            sw_min_reg   <= '0;
            digits_reg   <= 16'h0000;
            dp_reg       <= 4'b0100;
            colon_reg    <= 1'b0;
        end else begin
            div_reg      <= div_next;
            clk_sub_reg  <= clk_sub_next;
            clk_sec_reg  <= clk_sec_next;
            clk_min_reg  <= clk_min_next;
            clk_hour_reg <= clk_hour_next;
            state_reg    <= state_next;
            sw_csec_reg  <= sw_csec_next;
            sw_sec_reg   <= sw_sec_next;
            sw_min_reg   <= sw_min_next;
            digits_reg   <= digits_next;
            dp_reg       <= dp_next;
            colon_reg    <= colon_next;
        end
    end

    assign digits   = digits_reg;
    assign dp_mask  = dp_reg;
    assign colon    = colon_reg;
    assign sw_state = state_reg;

endmodule

// File: tb/tb_watch_core.sv
// -----------------------------------------------------------------------------
// tb_watch_core
// Directed bench for watch_core with CLK_HZ=1000, TICK_HZ=100 (tick every 10
// clocks). The stimulus process drives inputs on the falling edge and pushes
// the outputs it expects after the next rising edge. A separate monitor pops
// and compares them shortly after that rising edge.
//
// kcnt counts rising edges with rst high since the last reset release. The
// divider holds 0 during reset, so a tick is consumed at every rising edge
// where kcnt becomes a multiple of 10.
// -----------------------------------------------------------------------------
module tb_watch_core;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;

    logic        clk;
    logic        rst;
    logic        run_md;
    logic        disp_md;
    logic        clr_on;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic        colon;
    logic [1:0]  sw_state;

    watch_core #(
        .CLK_HZ (1000),
        .TICK_HZ(100)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .run_md  (run_md),
        .disp_md (disp_md),
        .clr_on  (clr_on),
        .digits  (digits),
        .dp_mask (dp_mask),
        .colon   (colon),
        .sw_state(sw_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int kcnt = 0;
    always @(posedge clk) begin
        if (!rst) kcnt <= 0;
        else      kcnt <= kcnt + 1;
    end

    typedef struct {
        string       name;
        logic [15:0] dg;
        logic [3:0]  dp;
        logic        cl;
        logic [1:0]  st;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Expectation for the outputs right after the next rising edge.
    task automatic expect_next(input string nm, input logic [15:0] dg,
                               input logic [3:0] dp, input logic cl,
                               input logic [1:0] st);
        exp_t e;
        e.name = nm;
        e.dg   = dg;
        e.dp   = dp;
        e.cl   = cl;
        e.st   = st;
        exp_q.push_back(e);
    endtask

    // Advance to the falling edge at which kcnt == n.
    task automatic goto(input int n);
        int guard;
        guard = 0;
        while (kcnt != n && guard < 50000) begin
            @(negedge clk);
            guard++;
        end
        if (kcnt != n) begin
            n_checks++;
            n_fail++;
            $display("FAIL goto: cycle count %0d, required %0d", kcnt, n);
        end
    endtask

    // Monitor: compare after each rising edge against whatever was queued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({digits, dp_mask, colon, sw_state} !== {e.dg, e.dp, e.cl, e.st}) begin
                    n_fail++;
                    $display("FAIL %s: got digits=%h dp=%b colon=%b state=%b, required digits=%h dp=%b colon=%b state=%b",
                             e.name, digits, dp_mask, colon, sw_state, e.dg, e.dp, e.cl, e.st);
                end else begin
                    $display("ok   %s: digits=%h dp=%b colon=%b state=%b",
                             e.name, digits, dp_mask, colon, sw_state);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #2_000_000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        rst = 1'b0; run_md = 1'b0; disp_md = 1'b0; clr_on = 1'b0;

        // Reset held for two edges
        @(negedge clk);
        expect_next("reset", 16'h0000, 4'b0100, 1'b0, ST_IDLE);
        @(negedge clk);
        rst = 1'b1; run_md = 1'b1;
        expect_next("idle_to_run", 16'h0000, 4'b0100, 1'b0, ST_RUN);

        // 1000 clocks of run: 99 ticks seen at edge 1000, 100 after it
        goto(999);  expect_next("run_0099", 16'h0099, 4'b0100, 1'b0, ST_RUN);
        goto(1000); run_md = 1'b0;
        expect_next("run_fall_1s", 16'h0100, 4'b0100, 1'b0, ST_PAUSE);
        goto(1010); expect_next("pause_hold", 16'h0100, 4'b0100, 1'b0, ST_PAUSE);

        // Resume with clear also high; the tick on the resume edge is ignored
        goto(1019); run_md = 1'b1; clr_on = 1'b1;
        expect_next("run_wins_clr", 16'h0100, 4'b0100, 1'b0, ST_RUN);
        goto(1020); expect_next("resume_tick_skip", 16'h0100, 4'b0100, 1'b0, ST_RUN);
        goto(1030); expect_next("resume_count", 16'h0101, 4'b0100, 1'b0, ST_RUN);

        // Stop on a tick edge: that tick is ignored
        goto(1039); run_md = 1'b0; clr_on = 1'b0;
        expect_next("stop_on_tick", 16'h0101, 4'b0100, 1'b0, ST_PAUSE);
        goto(1040); expect_next("stop_tick_skip", 16'h0101, 4'b0100, 1'b0, ST_PAUSE);

        // Clear from PAUSE
        goto(1041); clr_on = 1'b1;
        expect_next("clear_state", 16'h0101, 4'b0100, 1'b0, ST_IDLE);
        goto(1042); expect_next("clear_digits", 16'h0000, 4'b0100, 1'b0, ST_IDLE);
        goto(1043); clr_on = 1'b0;
        goto(1050); expect_next("idle_hold", 16'h0000, 4'b0100, 1'b0, ST_IDLE);

        // Stopwatch 00:59.99 -> 01:00.00 (MM.SS view)
        goto(1052); run_md = 1'b1;
        goto(1055);
        force dut.sw_min_reg  = 6'd0;
        force dut.sw_sec_reg  = 6'd59;
        force dut.sw_csec_reg = 7'd99;
        goto(1056);
        release dut.sw_min_reg;
        release dut.sw_sec_reg;
        release dut.sw_csec_reg;
        expect_next("sw_0059_99", 16'h5999, 4'b0100, 1'b0, ST_RUN);
        goto(1060); expect_next("sw_1min", 16'h0100, 4'b0100, 1'b0, ST_RUN);

        // Stopwatch 59:59.99 -> 00:00.00, stays RUN
        goto(1062);
        force dut.sw_min_reg  = 6'd59;
        force dut.sw_sec_reg  = 6'd59;
        force dut.sw_csec_reg = 7'd99;
        goto(1063);
        release dut.sw_min_reg;
        release dut.sw_sec_reg;
        release dut.sw_csec_reg;
        goto(1069); expect_next("sw_5959", 16'h5959, 4'b0100, 1'b0, ST_RUN);
        goto(1070); expect_next("sw_wrap", 16'h0000, 4'b0100, 1'b0, ST_RUN);

        // Clock view: 107 ticks so far -> 00:00:01, sub-second 7
        goto(1071); disp_md = 1'b1;
        expect_next("clk_view", 16'h0000, 4'b0000, 1'b1, ST_RUN);

        // Clock 00:59:59.99 -> 01:00:00
        goto(1072);
        force dut.clk_hour_reg = 5'd0;
        force dut.clk_min_reg  = 6'd59;
        force dut.clk_sec_reg  = 6'd59;
        force dut.clk_sub_reg  = 7'd99;
        goto(1073);
        release dut.clk_hour_reg;
        release dut.clk_min_reg;
        release dut.clk_sec_reg;
        release dut.clk_sub_reg;
        goto(1079); expect_next("clk_0059", 16'h0059, 4'b0000, 1'b0, ST_RUN);
        goto(1080); expect_next("clk_1h", 16'h0100, 4'b0000, 1'b1, ST_RUN);

        // Colon: high for sub 0..49, low for 50..99
        goto(1579); expect_next("colon_sub49", 16'h0100, 4'b0000, 1'b1, ST_RUN);
        goto(1580); expect_next("colon_sub50", 16'h0100, 4'b0000, 1'b0, ST_RUN);
        goto(2079); expect_next("colon_sub99", 16'h0100, 4'b0000, 1'b0, ST_RUN);
        goto(2080); expect_next("colon_sub0", 16'h0100, 4'b0000, 1'b1, ST_RUN);

        // Clock 23:59:59.99 -> 00:00:00
        goto(2082);
        force dut.clk_hour_reg = 5'd23;
        force dut.clk_min_reg  = 6'd59;
        force dut.clk_sec_reg  = 6'd59;
        force dut.clk_sub_reg  = 7'd99;
        goto(2083);
        release dut.clk_hour_reg;
        release dut.clk_min_reg;
        release dut.clk_sec_reg;
        release dut.clk_sub_reg;
        goto(2089); expect_next("clk_2359", 16'h2359, 4'b0000, 1'b0, ST_RUN);
        goto(2090); expect_next("clk_midnight", 16'h0000, 4'b0000, 1'b1, ST_RUN);

        // Reset in the middle of a run at 00:12.34
        goto(2091); disp_md = 1'b0;
        force dut.sw_min_reg  = 6'd0;
        force dut.sw_sec_reg  = 6'd12;
        force dut.sw_csec_reg = 7'd34;
        goto(2092);
        release dut.sw_min_reg;
        release dut.sw_sec_reg;
        release dut.sw_csec_reg;
        expect_next("sw_1234", 16'h1234, 4'b0100, 1'b0, ST_RUN);
        goto(2093); rst = 1'b0;
        expect_next("mid_run_reset", 16'h0000, 4'b0100, 1'b0, ST_IDLE);
        @(negedge clk);
        rst = 1'b1; run_md = 1'b0;
        expect_next("after_reset", 16'h0000, 4'b0100, 1'b0, ST_IDLE);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
